matrix_stream_loader: RTL and testbench

Upstream front end for the 3x3 8-bit matrix multiplier (`Calculator`). It accepts an 18-byte stream over a valid/ready handshake: 9 bytes of A, then 9 bytes of B, both row-major. It packs them into the multiplier's 72-bit A/B vectors, issues a one-cycle `mult_en`, and waits for `mult_done` under a timeout. It then captures the 144-bit product and holds it for a downstream consumer through a second valid/ready handshake.

---
 rtl/matmul_pkg.sv | 20 ++
 rtl/matrix_byte_packer.sv | 27 ++
 rtl/matrix_stream_loader.sv | 114 +++++++++++
 tb/tb_matrix_stream_loader.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared types and packing helpers for the 3x3 matrix multiplier front/back ends.
package matmul_pkg;
    localparam int ELEM_W = 8;
    localparam int N_ELEM = 9;
    localparam int RES_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_A,
        ST_LOAD_B,
        ST_START,
        ST_WAIT,
        ST_OUT
    } loader_state_t;

    // LSB of element k in a row-major vector of w-bit elements.
    function automatic int elem_lsb(input int k, input int w);
        return k * w;
    endfunction
endpackage

// File: rtl/matrix_byte_packer.sv
// Indexed byte write into a packed matrix register, with synchronous clear.
module matrix_byte_packer #(
    parameter int ELEM_W = 8,
    parameter int N_ELEM = 9
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     we,
    input  logic [3:0]               idx,
    input  logic [ELEM_W-1:0]        din,
    output logic [N_ELEM*ELEM_W-1:0] mat
);
    import matmul_pkg::*;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mat <= '0;
        end else if (clear) begin
            mat <= '0;
        end else if (we) begin
            for (int k = 0; k < N_ELEM; k++)
                if (idx == 4'(k))
                    mat[elem_lsb(k, ELEM_W) +: ELEM_W] <= din;
        end
    end
endmodule

// File: rtl/matrix_stream_loader.sv
// Streams 18 bytes into packed A/B, kicks the multiplier, and hands the product downstream.
module matrix_stream_loader #(
    parameter int ELEM_W  = 8,
    parameter int N_ELEM  = 9,
    parameter int TIMEOUT = 15,
    parameter int RES_W   = 2 * ELEM_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic [ELEM_W-1:0]        in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [N_ELEM*ELEM_W-1:0] mat_a,
    output logic [N_ELEM*ELEM_W-1:0] mat_b,
    output logic                     mult_en,
    input  logic                     mult_done,
    input  logic [N_ELEM*RES_W-1:0]  mult_result,
    output logic [N_ELEM*RES_W-1:0]  res_data,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic                     busy,
    output logic                     err_timeout
);
    import matmul_pkg::*;

    localparam int CW = $clog2(TIMEOUT + 1);

    loader_state_t state;
    logic [3:0]    idx;
    logic [CW-1:0] wcnt;
    logic          xfer, we_a, we_b;

    assign in_ready = (state == ST_IDLE) || (state == ST_LOAD_A) || (state == ST_LOAD_B);
    assign busy     = (state != ST_IDLE);
    assign xfer     = in_valid && in_ready;
    // idx is always 0 in IDLE, so the first byte lands in slot 0 of A.
    assign we_a     = xfer && ((state == ST_IDLE) || (state == ST_LOAD_A));
    assign we_b     = xfer && (state == ST_LOAD_B);

    matrix_byte_packer #(.ELEM_W(ELEM_W), .N_ELEM(N_ELEM)) u_pack_a (
        .clk(clk), .rst_n(rst_n), .clear(clear), .we(we_a), .idx(idx), .din(in_data), .mat(mat_a)
    );
    matrix_byte_packer #(.ELEM_W(ELEM_W), .N_ELEM(N_ELEM)) u_pack_b (
        .clk(clk), .rst_n(rst_n), .clear(clear), .we(we_b), .idx(idx), .din(in_data), .mat(mat_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            idx         <= '0;
            wcnt        <= '0;
            mult_en     <= 1'b0;
            res_data    <= '0;
            res_valid   <= 1'b0;
            err_timeout <= 1'b0;
        end else if (clear) begin
            state       <= ST_IDLE;
            idx         <= '0;
            wcnt        <= '0;
            mult_en     <= 1'b0;
            res_data    <= '0;
            res_valid   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            mult_en <= 1'b0;
            case (state)
                ST_IDLE: if (xfer) begin
                    idx   <= 4'd1;
                    state <= ST_LOAD_A;
                end
                ST_LOAD_A: if (xfer) begin
                    if (idx == 4'(N_ELEM - 1)) begin
                        idx   <= '0;
                        state <= ST_LOAD_B;
                    end else begin
                        idx <= idx + 4'd1;
                    end
                end
                ST_LOAD_B: if (xfer) begin
                    if (idx == 4'(N_ELEM - 1)) begin
                        idx     <= '0;
                        mult_en <= 1'b1;
                        state   <= ST_START;
                    end else begin
                        idx <= idx + 4'd1;
                    end
                end
                ST_START: begin
                    wcnt  <= '0;
                    state <= ST_WAIT;
                end
                // A stale-high mult_done is fine: the result was refreshed on the START edge.
                ST_WAIT: begin
                    if (mult_done) begin
                        res_data  <= mult_result;
                        res_valid <= 1'b1;
                        state     <= ST_OUT;
                    end else if (wcnt == CW'(TIMEOUT - 1)) begin
                        err_timeout <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                ST_OUT: if (res_valid && res_ready) begin
                    res_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_matrix_stream_loader.sv
// Randomized self-checking bench for matrix_stream_loader with a behavioural multiplier stand-in.
module tb_matrix_stream_loader;
    typedef logic [7:0] bytes_t [18];

    logic         clk = 0, rst_n, clear, in_valid, in_ready, mult_en, mult_done;
    logic         res_valid, res_ready, busy, err_timeout;
    logic [7:0]   in_data;
    logic [71:0]  mat_a, mat_b;
    logic [143:0] mult_result, res_data;

    int nvec = 0, nerr = 0, en_pulses = 0;
    logic done_r, stub_dead;

    matrix_stream_loader dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mat_a(mat_a), .mat_b(mat_b), .mult_en(mult_en),
        .mult_done(mult_done), .mult_result(mult_result), .res_data(res_data),
        .res_valid(res_valid), .res_ready(res_ready), .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // C = A*B over 3x3 row-major byte matrices, each element truncated to 16 bits.
    function automatic logic [143:0] ref_product(input bytes_t b);
        logic [143:0] r;
        int s;
        r = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                s = 0;
                for (int k = 0; k < 3; k++) s += int'(b[i*3+k]) * int'(b[9+k*3+j]);
                r[(i*3+j)*16 +: 16] = s[15:0];
            end
        return r;
    endfunction

    function automatic logic [71:0] pack9(input bytes_t b, input int off);
        logic [71:0] r;
        for (int k = 0; k < 9; k++) r[k*8 +: 8] = b[off+k];
        return r;
    endfunction

    // Multiplier stand-in: result registered on the START edge, done sticky until reset.
    always @(posedge clk or negedge rst_n) begin
        bytes_t t;
        if (!rst_n) begin
            done_r <= 1'b0;
            mult_result <= '0;
        end else if (mult_en) begin
            for (int k = 0; k < 9; k++) begin
                t[k]   = mat_a[k*8 +: 8];
                t[9+k] = mat_b[k*8 +: 8];
            end
            mult_result <= ref_product(t);
            done_r <= 1'b1;
        end
    end
    assign mult_done = done_r & ~stub_dead;

    always @(negedge clk) if (mult_en) en_pulses++;

    task automatic rand_bytes(output bytes_t b);
        for (int k = 0; k < 18; k++) b[k] = 8'($urandom_range(255));
    endtask

    task automatic send_bytes(input bytes_t b, input int n, input int gap);
        int i = 0, guard = 0;
        bit acc;
        while (i < n && guard < 2000) begin
            @(negedge clk);
            guard++;
            if (gap > 0 && $urandom_range(99) < gap) in_valid = 1'b0;
            else begin in_valid = 1'b1; in_data = b[i]; end
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) i++;
        end
        #1 in_valid = 1'b0;
        nvec++;
        if (i != n) begin nerr++; $display("FAIL send_bytes: accepted %0d, required %0d", i, n); end
    endtask

    task automatic run_and_check(input bytes_t b, input int gap, input int hold, input string nm);
        logic [143:0] exp;
        int w = 0;
        exp = ref_product(b);
        res_ready = (hold == 0);
        send_bytes(b, 18, gap);
        @(negedge clk);
        while (!res_valid && w < 40) begin @(negedge clk); w++; end
        nvec++;
        if (res_valid !== 1'b1) begin nerr++; $display("FAIL %s res_valid: got %b, required 1", nm, res_valid); end
        nvec++;
        if (res_data !== exp) begin nerr++; $display("FAIL %s res_data: got %h, required %h", nm, res_data, exp); end
        nvec++;
        if (mat_a !== pack9(b, 0) || mat_b !== pack9(b, 9))
            begin nerr++; $display("FAIL %s packing: got %h/%h, required %h/%h", nm, mat_a, mat_b, pack9(b, 0), pack9(b, 9)); end
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            nvec++;
            if (res_data !== exp || res_valid !== 1'b1 || in_ready !== 1'b0)
                begin nerr++; $display("FAIL %s stall cyc %0d: data %h v %b rdy %b, required %h 1 0", nm, c, res_data, res_valid, in_ready, exp); end
        end
        res_ready = 1'b1;
        if (hold > 0) @(negedge clk);
        @(negedge clk);
        nvec++;
        if (res_valid !== 1'b0 || busy !== 1'b0)
            begin nerr++; $display("FAIL %s release: valid %b busy %b, required 0 0", nm, res_valid, busy); end
    endtask

    task automatic check_reset_vals(input string nm);
        nvec++;
        if (in_ready !== 1 || busy !== 0 || mult_en !== 0 || res_valid !== 0 || err_timeout !== 0 ||
            mat_a !== '0 || mat_b !== '0 || res_data !== '0)
            begin nerr++; $display("FAIL %s: rdy %b busy %b en %b v %b err %b a %h b %h r %h, required reset values",
                                   nm, in_ready, busy, mult_en, res_valid, err_timeout, mat_a, mat_b, res_data); end
    endtask

    task automatic test_reset();
        #1 check_reset_vals("reset_asserted");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals("reset_released");
    endtask

    task automatic test_identity();
        bytes_t b;
        int p0;
        b = '{1,0,0,0,1,0,0,0,1, 1,2,3,4,5,6,7,8,9};
        res_ready = 1'b1;
        p0 = en_pulses;
        send_bytes(b, 18, 0);
        @(negedge clk);
        nvec++;
        if (mult_en !== 1'b1) begin nerr++; $display("FAIL ident start: mult_en %b, required 1", mult_en); end
        @(negedge clk);
        nvec++;
        if (mult_en !== 1'b0 || res_valid !== 1'b0)
            begin nerr++; $display("FAIL ident wait: en %b valid %b, required 0 0", mult_en, res_valid); end
        @(negedge clk);
        nvec++;
        if (res_valid !== 1'b1 || res_data !== {16'd9,16'd8,16'd7,16'd6,16'd5,16'd4,16'd3,16'd2,16'd1})
            begin nerr++; $display("FAIL ident result: valid %b data %h", res_valid, res_data); end
        @(negedge clk);
        nvec++;
        if (busy !== 1'b0 || en_pulses - p0 !== 1)
            begin nerr++; $display("FAIL ident end: busy %b pulses %0d, required 0 1", busy, en_pulses - p0); end
    endtask

    task automatic test_saturate();
        bytes_t b;
        for (int k = 0; k < 18; k++) b[k] = 8'hFF;
        run_and_check(b, 0, 0, "saturate");
        nvec++;
        if (res_data[143:128] !== 16'd64003 || res_data[15:0] !== 16'd64003 || mat_a !== {72{1'b1}})
            begin nerr++; $display("FAIL saturate const: got %h a %h, required 64003 each", res_data, mat_a); end
    endtask

    task automatic test_stalls();
        bytes_t b;
        rand_bytes(b);
        run_and_check(b, 40, 10, "stalls");
    endtask

    task automatic test_timeout();
        bytes_t b;
        rand_bytes(b);
        stub_dead = 1'b1;
        res_ready = 1'b1;
        send_bytes(b, 18, 0);
        @(negedge clk);
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (k == 15) begin
                nvec++;
                if (err_timeout !== 1'b0 || busy !== 1'b1)
                    begin nerr++; $display("FAIL timeout early: err %b busy %b, required 0 1", err_timeout, busy); end
            end
        end
        @(negedge clk);
        nvec++;
        if (err_timeout !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0)
            begin nerr++; $display("FAIL timeout flag: err %b busy %b valid %b, required 1 0 0", err_timeout, busy, res_valid); end
        repeat (3) @(negedge clk);
        nvec++;
        if (err_timeout !== 1'b1 || in_ready !== 1'b1)
            begin nerr++; $display("FAIL timeout sticky: err %b rdy %b, required 1 1", err_timeout, in_ready); end
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        nvec++;
        if (err_timeout !== 1'b0 || mat_a !== '0)
            begin nerr++; $display("FAIL timeout clear: err %b a %h, required 0 0", err_timeout, mat_a); end
        stub_dead = 1'b0;
    endtask

    task automatic test_abort();
        bytes_t b;
        rand_bytes(b);
        send_bytes(b, 5, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1 check_reset_vals("abort_reset");
        @(negedge clk);
        rst_n = 1'b1;
        rand_bytes(b);
        run_and_check(b, 0, 0, "after_reset");
        rand_bytes(b);
        send_bytes(b, 12, 0);
        @(negedge clk);
        clear = 1'b1; in_valid = 1'b1; in_data = 8'hA5;
        @(negedge clk);
        check_reset_vals("abort_clear");
        clear = 1'b0; in_valid = 1'b0;
        rand_bytes(b);
        run_and_check(b, 20, 2, "after_clear");
    endtask

    task automatic test_back_to_back();
        bytes_t b;
        for (int r = 0; r < 2; r++) begin
            rand_bytes(b);
            run_and_check(b, 0, 0, "b2b");
        end
    endtask

    task automatic test_random();
        bytes_t b;
        for (int r = 0; r < 5; r++) begin
            rand_bytes(b);
            run_and_check(b, $urandom_range(50), $urandom_range(5), "random");
        end
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0;
        res_ready = 1'b1; stub_dead = 1'b0;
        test_reset();
        test_identity();
        test_saturate();
        test_stalls();
        test_timeout();
        test_abort();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
